// File: rtl/mc_array_seq.sv
// Access sequencer for the 64x64 RRAM macro: one read-row or write-bit request at a time.
// Optional write-verify with retries is enabled by defining FRAISE_WRITE_VERIFY_EN.
module mc_array_seq #(
  parameter int T_SETUP   = 2,
  parameter int T_PULSE   = 4,
  parameter int T_SENSE   = 3,
  parameter int T_RECOV   = 1,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [5:0]  req_row_i,
  input  logic [5:0]  req_col_i,
  input  logic        req_wbit_i,
  output logic        rsp_valid_o,
  output logic [63:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [31:0] cwle_o,
  output logic [31:0] cwlo_o,
  output logic [63:0] cbl_o,
  output logic [63:0] csl_o,
  output logic [63:0] cblen_o,
  output logic [63:0] din_o,
  output logic [63:0] dinb_o,
  input  logic [63:0] dout_i
);

  localparam int TMAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int TMAX_B = (T_SENSE > T_RECOV) ? T_SENSE : T_RECOV;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int CW     = $clog2(TMAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACTIVE, S_RECOV, S_DONE
`ifdef FRAISE_WRITE_VERIFY_EN
    , S_VSETUP, S_VSENSE, S_VRECOV
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [5:0]     row_q, row_d;
  logic [5:0]     col_q, col_d;
  logic           wbit_q, wbit_d;
  logic [63:0]    data_q, data_d;
  logic           last;
`ifdef FRAISE_WRITE_VERIFY_EN
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  logic [RW-1:0]  retry_q, retry_d;
  logic           err_q, err_d;
`endif

  // Phase length minus one, loaded whenever a timed state is entered.
  function automatic logic [CW-1:0] phase_load(input state_t s, input logic we);
    logic [CW-1:0] v;
    v = '0;
    case (s)
      S_SETUP:  v = CW'(T_SETUP - 1);
      S_ACTIVE: v = we ? CW'(T_PULSE - 1) : CW'(T_SENSE - 1);
      S_RECOV:  v = CW'(T_RECOV - 1);
`ifdef FRAISE_WRITE_VERIFY_EN
      S_VSETUP: v = CW'(T_SETUP - 1);
      S_VSENSE: v = CW'(T_SENSE - 1);
      S_VRECOV: v = CW'(T_RECOV - 1);
`endif
      default:  v = '0;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      wbit_q  <= 1'b0;
      data_q  <= '0;
`ifdef FRAISE_WRITE_VERIFY_EN
      retry_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wbit_q  <= wbit_d;
      data_q  <= data_d;
`ifdef FRAISE_WRITE_VERIFY_EN
      retry_q <= retry_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    row_d   = row_q;
    col_d   = col_q;
    wbit_d  = wbit_q;
    data_d  = data_q;
    last    = (cnt_q == '0);
`ifdef FRAISE_WRITE_VERIFY_EN
    retry_d = retry_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_SETUP;
          we_d    = req_we_i;
          row_d   = req_row_i;
          col_d   = req_col_i;
          wbit_d  = req_wbit_i;
          data_d  = '0;
`ifdef FRAISE_WRITE_VERIFY_EN
          retry_d = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_SETUP:  if (last) state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (last) begin
          state_d = S_RECOV;
          if (!we_q) data_d = dout_i;
        end
      end
      S_RECOV: begin
        if (last) begin
`ifdef FRAISE_WRITE_VERIFY_EN
          state_d = we_q ? S_VSETUP : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef FRAISE_WRITE_VERIFY_EN
      S_VSETUP: if (last) state_d = S_VSENSE;
      S_VSENSE: begin
        if (last) begin
          state_d = S_VRECOV;
          data_d  = dout_i;
        end
      end
      // Readback already sits in data_q; decide pass, retry or give up.
      S_VRECOV: begin
        if (last) begin
          if (data_q[col_q] == wbit_q) begin
            state_d = S_DONE;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = S_SETUP;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = phase_load(state_d, we_d);
    else if (!last)         cnt_d = cnt_q - CW'(1);
    else                    cnt_d = cnt_q;
  end

  logic wl_on, col_sel, col_drv, blen;

  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    cwle_o      = '0;
    cwlo_o      = '0;
    cbl_o       = '0;
    csl_o       = '0;
    cblen_o     = '0;
    din_o       = '0;
    dinb_o      = '0;
    wl_on       = 1'b0;
    col_sel     = 1'b0;
    col_drv     = 1'b0;
    blen        = 1'b0;
    case (state_q)
      S_IDLE:   req_ready_o = 1'b1;
      S_SETUP: begin
        wl_on   = 1'b1;
        col_sel = we_q;
        blen    = ~we_q;
      end
      S_ACTIVE: begin
        wl_on   = 1'b1;
        col_sel = we_q;
        col_drv = we_q;
        blen    = ~we_q;
      end
`ifdef FRAISE_WRITE_VERIFY_EN
      S_VSETUP, S_VSENSE: begin
        wl_on = 1'b1;
        blen  = 1'b1;
      end
`endif
      S_DONE:   rsp_valid_o = 1'b1;
      default:  ;
    endcase
    if (wl_on) begin
      if (row_q[0]) cwlo_o[row_q[5:1]] = 1'b1;
      else          cwle_o[row_q[5:1]] = 1'b1;
    end
    if (col_sel) begin
      cbl_o[col_q] = 1'b1;
      csl_o[col_q] = 1'b1;
    end
    if (col_drv) begin
      din_o[col_q]  = wbit_q;
      dinb_o[col_q] = ~wbit_q;
    end
    if (blen) cblen_o = '1;
  end

  assign rsp_data_o = data_q;
`ifdef FRAISE_WRITE_VERIFY_EN
  assign rsp_err_o  = err_q;
`else
  assign rsp_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mc_array_seq.sv
// Directed bench for mc_array_seq; cycle n=1 is the first cycle after the accepting edge.
module tb_mc_array_seq;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i, req_wbit_i;
  logic [5:0]  req_row_i, req_col_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [63:0] rsp_data_o;
  logic [31:0] cwle_o, cwlo_o;
  logic [63:0] cbl_o, csl_o, cblen_o, din_o, dinb_o, dout_i;

  int total = 0;
  int bad   = 0;

  mc_array_seq dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_row_i(req_row_i), .req_col_i(req_col_i), .req_wbit_i(req_wbit_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .cwle_o(cwle_o), .cwlo_o(cwlo_o), .cbl_o(cbl_o), .csl_o(csl_o),
    .cblen_o(cblen_o), .din_o(din_o), .dinb_o(dinb_o), .dout_i(dout_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic any_pin();
    return |{cwle_o, cwlo_o, cbl_o, csl_o, cblen_o, din_o, dinb_o};
  endfunction

  // Called #1 after an edge; returns #1 after the accepting edge (n=1).
  task automatic start_req(input logic we, input logic [5:0] row, input logic [5:0] col,
                           input logic wbit, input logic hold);
    int w;
    w = 0;
    while (req_ready_o !== 1'b1 && w < 20) begin
      @(posedge clk_i); #1; w++;
    end
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++; $display("FAIL accept_wait ready=%b expected=1", req_ready_o);
    end
    req_we_i = we; req_row_i = row; req_col_i = col; req_wbit_i = wbit;
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    if (!hold) req_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
    total++;
    if ({rsp_valid_o, rsp_err_o} !== 2'b00) begin
      bad++; $display("FAIL reset_rsp got=%b exp=00", {rsp_valid_o, rsp_err_o});
    end
    total++;
    if (rsp_data_o !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", rsp_data_o); end
    total++;
    if (any_pin() !== 1'b0) begin bad++; $display("FAIL reset_pins got=%b exp=0", any_pin()); end
  endtask

  task automatic test_read();
    logic [63:0] d, exp_wl, exp_blen;
    d = 64'hDEAD_BEEF_0123_4567;
    dout_i = d;
    start_req(1'b0, 6'd10, 6'd0, 1'b0, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      exp_wl   = (n <= 5) ? 64'h20 : 64'h0;
      exp_blen = (n <= 5) ? '1 : '0;
      total++;
      if ({cwlo_o, cwle_o} !== exp_wl) begin
        bad++; $display("FAIL read_wl n=%0d got=%h exp=%h", n, {cwlo_o, cwle_o}, exp_wl);
      end
      total++;
      if (cblen_o !== exp_blen || cbl_o !== 64'h0 || din_o !== 64'h0) begin
        bad++; $display("FAIL read_cols n=%0d cblen=%h exp=%h", n, cblen_o, exp_blen);
      end
      total++;
      if (rsp_valid_o !== (n == 7)) begin
        bad++; $display("FAIL read_valid n=%0d got=%b exp=%b", n, rsp_valid_o, (n == 7));
      end
      total++;
      if (req_ready_o !== (n == 8)) begin
        bad++; $display("FAIL read_ready n=%0d got=%b exp=%b", n, req_ready_o, (n == 8));
      end
      if (n == 7) begin
        total++;
        if (rsp_data_o !== d) begin bad++; $display("FAIL read_data got=%h exp=%h", rsp_data_o, d); end
      end
      @(posedge clk_i); #1;
    end
  endtask

`ifndef FRAISE_WRITE_VERIFY_EN
  task automatic test_write_set();
    logic [63:0] exp_wl, exp_col, exp_din;
    int pulses;
    pulses = 0;
    dout_i = 64'hFFFF_0000_FFFF_0000;
    start_req(1'b1, 6'd63, 6'd5, 1'b1, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      exp_wl  = (n <= 6) ? 64'h8000_0000_0000_0000 : 64'h0;
      exp_col = (n <= 6) ? 64'h20 : 64'h0;
      exp_din = (n >= 3 && n <= 6) ? 64'h20 : 64'h0;
      if (din_o == 64'h20) pulses++;
      total++;
      if ({cwlo_o, cwle_o} !== exp_wl) begin
        bad++; $display("FAIL wset_wl n=%0d got=%h exp=%h", n, {cwlo_o, cwle_o}, exp_wl);
      end
      total++;
      if (cbl_o !== exp_col || csl_o !== exp_col || cblen_o !== 64'h0) begin
        bad++; $display("FAIL wset_cols n=%0d cbl=%h csl=%h exp=%h", n, cbl_o, csl_o, exp_col);
      end
      total++;
      if (din_o !== exp_din || dinb_o !== 64'h0) begin
        bad++; $display("FAIL wset_din n=%0d din=%h dinb=%h exp_din=%h", n, din_o, dinb_o, exp_din);
      end
      total++;
      if (rsp_valid_o !== (n == 8)) begin
        bad++; $display("FAIL wset_valid n=%0d got=%b exp=%b", n, rsp_valid_o, (n == 8));
      end
      if (n == 8) begin
        total++;
        if (rsp_data_o !== 64'h0 || rsp_err_o !== 1'b0) begin
          bad++; $display("FAIL wset_rsp data=%h err=%b exp=0/0", rsp_data_o, rsp_err_o);
        end
      end
      @(posedge clk_i); #1;
    end
    total++;
    if (pulses != 4) begin bad++; $display("FAIL wset_pulses got=%0d exp=4", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d, exp_wl, exp_col, exp_dinb, exp_blen;
    d = 64'h0123_4567_89AB_CDEF;
    dout_i = d;
    start_req(1'b1, 6'd0, 6'd63, 1'b0, 1'b1);
    // Fields change while valid stays high; the write must keep its captured fields.
    req_we_i = 1'b0; req_row_i = 6'd1; req_col_i = 6'd0; req_wbit_i = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      exp_wl   = (n <= 6) ? 64'h1 : ((n >= 10 && n <= 14) ? 64'h1_0000_0000 : 64'h0);
      exp_col  = (n <= 6) ? 64'h8000_0000_0000_0000 : 64'h0;
      exp_dinb = (n >= 3 && n <= 6) ? 64'h8000_0000_0000_0000 : 64'h0;
      exp_blen = (n >= 10 && n <= 14) ? '1 : '0;
      if (n == 10) req_valid_i = 1'b0;
      total++;
      if ({cwlo_o, cwle_o} !== exp_wl) begin
        bad++; $display("FAIL b2b_wl n=%0d got=%h exp=%h", n, {cwlo_o, cwle_o}, exp_wl);
      end
      total++;
      if (cbl_o !== exp_col || csl_o !== exp_col || cblen_o !== exp_blen) begin
        bad++; $display("FAIL b2b_cols n=%0d cbl=%h cblen=%h exp=%h/%h", n, cbl_o, cblen_o, exp_col, exp_blen);
      end
      total++;
      if (dinb_o !== exp_dinb || din_o !== 64'h0) begin
        bad++; $display("FAIL b2b_din n=%0d dinb=%h din=%h exp_dinb=%h", n, dinb_o, din_o, exp_dinb);
      end
      total++;
      if (req_ready_o !== (n == 9 || n == 17)) begin
        bad++; $display("FAIL b2b_ready n=%0d got=%b", n, req_ready_o);
      end
      total++;
      if (rsp_valid_o !== (n == 8 || n == 16)) begin
        bad++; $display("FAIL b2b_valid n=%0d got=%b", n, rsp_valid_o);
      end
      if (n == 8) begin
        total++;
        if (rsp_data_o !== 64'h0) begin bad++; $display("FAIL b2b_wdata got=%h exp=0", rsp_data_o); end
      end
      if (n == 16) begin
        total++;
        if (rsp_data_o !== d) begin bad++; $display("FAIL b2b_rdata got=%h exp=%h", rsp_data_o, d); end
      end
      if (n < 17) begin @(posedge clk_i); #1; end
    end
  endtask
`else
  task automatic verify_run(input logic [63:0] d, input int exp_pulses, input int exp_lat,
                            input logic exp_err);
    int pulses, lat;
    pulses = 0; lat = -1;
    dout_i = d;
    start_req(1'b1, 6'd3, 6'd7, 1'b1, 1'b0);
    for (int n = 1; n <= 80 && lat < 0; n++) begin
      if (din_o == 64'h80) pulses++;
      if (din_o != 64'h0 && cwlo_o !== 32'h2) begin
        total++; bad++; $display("FAIL ver_wl n=%0d cwlo=%h exp=2", n, cwlo_o);
      end
      if (rsp_valid_o === 1'b1) begin
        lat = n;
        total++;
        if (rsp_err_o !== exp_err || rsp_data_o !== d) begin
          bad++; $display("FAIL ver_rsp err=%b data=%h exp=%b/%h", rsp_err_o, rsp_data_o, exp_err, d);
        end
      end
      @(posedge clk_i); #1;
    end
    total++;
    if (lat != exp_lat) begin bad++; $display("FAIL ver_latency got=%0d exp=%0d", lat, exp_lat); end
    total++;
    if (pulses != exp_pulses) begin bad++; $display("FAIL ver_pulses got=%0d exp=%0d", pulses, exp_pulses); end
  endtask

  task automatic test_verify();
    verify_run(64'h0, 16, 53, 1'b1);
    verify_run(64'h80, 4, 14, 1'b0);
  endtask
`endif

  task automatic test_reset_mid();
    logic seen;
    logic [63:0] d;
    start_req(1'b1, 6'd20, 6'd9, 1'b1, 1'b0);
    repeat (3) begin @(posedge clk_i); #1; end
    total++;
    if (din_o !== 64'h200) begin bad++; $display("FAIL rmid_pre din=%h exp=200", din_o); end
    rst_i = 1'b1;
    #1;
    total++;
    if (any_pin() !== 1'b0 || rsp_valid_o !== 1'b0) begin
      bad++; $display("FAIL rmid_pins pins=%b valid=%b exp=0/0", any_pin(), rsp_valid_o);
    end
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    total++;
    if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", req_ready_o); end
    seen = 1'b0;
    repeat (10) begin
      if (rsp_valid_o === 1'b1 || any_pin() === 1'b1) seen = 1'b1;
      @(posedge clk_i); #1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rmid_ghost got=%b exp=0", seen); end
    d = 64'h5A5A_0F0F_C3C3_9669;
    dout_i = d;
    start_req(1'b0, 6'd2, 6'd0, 1'b0, 1'b0);
    for (int n = 1; n <= 7; n++) begin
      if (n == 3) begin
        total++;
        if (cwle_o !== 32'h2) begin bad++; $display("FAIL rmid_rd_wl got=%h exp=2", cwle_o); end
      end
      total++;
      if (rsp_valid_o !== (n == 7)) begin
        bad++; $display("FAIL rmid_rd_valid n=%0d got=%b exp=%b", n, rsp_valid_o, (n == 7));
      end
      if (n == 7) begin
        total++;
        if (rsp_data_o !== d) begin bad++; $display("FAIL rmid_rd_data got=%h exp=%h", rsp_data_o, d); end
      end
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_wbit_i = 1'b0;
    req_row_i = '0; req_col_i = '0; dout_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    test_reset();
    test_read();
`ifndef FRAISE_WRITE_VERIFY_EN
    test_write_set();
    test_back_to_back();
`else
    test_verify();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/mc_array_seq.md
# mc_array_seq

Access sequencer for the 64x64 RRAM macro array. It accepts single-request read-row / write-bit commands on a valid/ready port and generates the timed control waveforms on the macro's word-line, bit-line, source-line and data pins. It samples the macro's `DOUT` and returns one response per request. It sits between the system-side memory interface and the macro instance, and is the only driver of the macro's control pins.

## Interface
- `T_SETUP`, default 2: cycles the word line and column select are asserted before the active phase; minimum 1.
- `T_PULSE`, default 4: write pulse width in cycles (DIN/DINb active); minimum 1.
- `T_SENSE`, default 3: read sense width in cycles; minimum 1.
- `T_RECOV`, default 1: all-off recovery cycles after the active phase; minimum 1.
- `MAX_RETRY`, default 3: number of rewrite attempts under write-verify.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous reset, active-high.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready.
- `req_we_i`  in  1  1 = write bit, 0 = read row.
- `req_row_i`  in  6  row address 0..63.
- `req_col_i`  in  6  column address, used by writes only.
- `req_wbit_i`  in  1  write value: 1 = SET, 0 = RESET.
- `rsp_valid_o`  out  1  one-cycle response strobe.
- `rsp_data_o`  out  64  read row data, or the readback row after a verified write.
- `rsp_err_o`  out  1  write-verify failure.
- `cwle_o`  out  32  even word lines; row r even drives bit r>>1.
- `cwlo_o`  out  32  odd word lines; row r odd drives bit r>>1.
- `cbl_o`, `csl_o`, `cblen_o`, `din_o`, `dinb_o`  out  64 each  macro column controls.
- `dout_i`  in  64  macro sense outputs.

## Operation
- FSM states: IDLE, SETUP, ACTIVE, RECOV, DONE; VERIFY_* states exist only with the macro enabled.
- Request capture:
  - `req_ready_o` = 1 only in IDLE.
  - On `req_valid_i & req_ready_o`, latch we, row, col and wbit, then go to SETUP.
- SETUP (`T_SETUP` cycles): the selected word line is 1.
  - Write: `cbl_o[col]` = `csl_o[col]` = 1.
  - Read: `cblen_o` = all ones.
- ACTIVE: SETUP drives are held.
  - Write (`T_PULSE` cycles): `din_o[col]` = wbit, `dinb_o[col]` = ~wbit.
  - Read (`T_SENSE` cycles): `dout_i` is registered into `rsp_data_o` on the last ACTIVE cycle.
- RECOV (`T_RECOV` cycles): every macro output is 0.
- DONE (1 cycle): `rsp_valid_o` = 1, then go to IDLE. Responses have no backpressure.
- Outside the state that asserts them, all macro outputs are 0.
- At most one word line and at most one write column are ever high.
- A single down-counter sized to $clog2 of the largest T parameter, plus 1, times each phase. It is reloaded on every state entry.
- Without write-verify: write responses return `rsp_data_o` = 0 and `rsp_err_o` = 0.

## Timing
- Request accepted at clock edge k. `rsp_valid_o` is high in cycle k + 1 + T_SETUP + T_ACTIVE + T_RECOV.
  - Defaults: read latency 7, write latency 8.
- `req_ready_o` returns to 1 the cycle after DONE, so the next accept happens no earlier than that cycle.
- `req_valid_i` outside IDLE is ignored. Request fields are sampled only at accept.
- Reset values: `req_ready_o` = 1 after reset release. All other outputs are 0, including `rsp_data_o`, `rsp_valid_o`, `rsp_err_o` and every macro pin.
- Reset mid-operation: macro pins drop to 0 asynchronously, with no response for the aborted request.
- Row mapping boundaries:
  - row 0 → `cwle_o[0]`.
  - row 1 → `cwlo_o[0]`.
  - row 63 → `cwlo_o[31]`.

## Configuration
- Macro: `FRAISE_WRITE_VERIFY_EN`.
- Defined:
  - After the write RECOV, run a read sequence (SETUP, SENSE, RECOV) on the same row.
  - If `dout_i[col]` == wbit: DONE with `rsp_err_o` = 0 and `rsp_data_o` = readback row.
  - On mismatch with retry count < `MAX_RETRY`: increment the count and rerun the write from SETUP.
  - On mismatch after `MAX_RETRY` retries: DONE with `rsp_err_o` = 1 and `rsp_data_o` = last readback.
  - The retry count clears on accept.
  - Default write latency with one verify pass: 1 + 2 + 4 + 1 + 2 + 3 + 1 = 14.
- Undefined: no verify logic, `rsp_err_o` tied 0.

## Test plan
- Reset, then read row 10 with `dout_i` = 64'hDEAD_BEEF_0123_4567 → `cwle_o` = 32'h20 during SETUP/ACTIVE, `cblen_o` all ones, `rsp_valid_o` at cycle 7, `rsp_data_o` = 64'hDEAD_BEEF_0123_4567.
- Write SET to row 63, col 5 → `cwlo_o[31]` = 1, `cbl_o` = `csl_o` = 64'h20, `din_o` = 64'h20 and `dinb_o` = 0 for exactly 4 cycles, response at cycle 8.
- Write RESET to row 0, col 63 → `cwle_o[0]`, `dinb_o[63]` = 1 for 4 cycles, `din_o` = 0; back-to-back `req_valid_i` held high is accepted only the cycle after DONE.
- `FRAISE_WRITE_VERIFY_EN`, `dout_i` stuck at 0, write SET → 4 write pulses (1 + `MAX_RETRY`), `rsp_err_o` = 1. Repeat with `dout_i[col]` = 1 → single pulse, `rsp_err_o` = 0, response at cycle 14.
- Assert `rst_i` in the 2nd ACTIVE cycle of a write → all macro pins 0 in the same cycle, no `rsp_valid_o`, `req_ready_o` = 1 after release, and the next read completes normally.
